// File: rtl/OpTypes.sv
// ============================================================================
// Module   : OpTypes (package)
// Purpose  : Command and state encodings shared by the mul/div unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package OpTypes;

    // Encoding follows the RISC-V M-extension funct3 ordering.
    typedef enum logic [2:0] {
        Mul    = 3'd0,
        Mulh   = 3'd1,
        Mulhsu = 3'd2,
        Mulhu  = 3'd3,
        Div    = 3'd4,
        Divu   = 3'd5,
        Rem    = 3'd6,
        Remu   = 3'd7
    } MulDivCommand;

    typedef enum logic [1:0] {
        Idle    = 2'd0,
        Compute = 2'd1,
        Done    = 2'd2
    } MulDivState;

    localparam int MulDivIterations = 32;

    function automatic logic is_mul(input MulDivCommand c);
        return c inside {Mul, Mulh, Mulhsu, Mulhu};
    endfunction

endpackage

`default_nettype wire

// File: rtl/mul_div_unit_divider.sv
// ============================================================================
// Module   : mul_div_divider
// Purpose  : Unsigned restoring divider retiring one quotient bit per step.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_div_divider (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    logic [31:0] quo_q, quo_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] dvs_q, dvs_d;
    logic [32:0] shifted;
    logic        fits;
    logic [31:0] quo_nxt, rem_nxt;

    // A successful trial subtract is below the divisor, so 32 bits hold it.
    assign shifted = {rem_q, quo_q[31]};
    assign fits    = shifted >= {1'b0, dvs_q};
    assign rem_nxt = fits ? (shifted[31:0] - dvs_q) : shifted[31:0];
    assign quo_nxt = {quo_q[30:0], fits};

    // Outputs show the value after the step being taken this cycle.
    assign quotient  = quo_nxt;
    assign remainder = rem_nxt;

    always_comb begin
        quo_d = quo_q;
        rem_d = rem_q;
        dvs_d = dvs_q;
        if (load) begin
            quo_d = dividend;
            rem_d = '0;
            dvs_d = divisor;
        end else if (step) begin
            quo_d = quo_nxt;
            rem_d = rem_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
        end else begin
            quo_q <= quo_d;
            rem_q <= rem_d;
            dvs_q <= dvs_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mul_div_unit.sv
// ============================================================================
// Module   : mul_div_unit
// Purpose  : Iterative RV32M multiply/divide unit. Define MUL_DIV_FAST_MUL_EN
//            for a single-cycle multiplier on all multiply commands.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_div_unit
    import OpTypes::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         flush,
    input  MulDivCommand command,
    input  logic [31:0]  src1,
    input  logic [31:0]  src2,
    output logic         busy,
    output logic         done,
    output logic [31:0]  result
);

    MulDivState   state_q, state_d;
    MulDivCommand cmd_q, cmd_d;
    logic [4:0]   cnt_q, cnt_d;
    logic [31:0]  mcand_q, mcand_d;
    logic [63:0]  prod_q, prod_d;
    logic         neg_q, neg_d;
    logic         rneg_q, rneg_d;
    logic [31:0]  result_q, result_d;

    logic         a_sgn, b_sgn;
    logic [31:0]  a_mag, b_mag;
    logic         div_load, div_step;
    logic [31:0]  div_quo, div_rem;
    logic [32:0]  mul_sum;
    logic [63:0]  prod_nxt, prod_fix;
    logic [31:0]  quo_fix, rem_fix;

    assign a_sgn = command inside {Mulh, Mulhsu, Div, Rem};
    assign b_sgn = command inside {Mulh, Div, Rem};
    assign a_mag = (a_sgn && src1[31]) ? -src1 : src1;
    assign b_mag = (b_sgn && src2[31]) ? -src2 : src2;

    // Shift-add on magnitudes: multiplier sits in the low half and drains out.
    assign mul_sum  = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, mcand_q} : 33'd0);
    assign prod_nxt = {mul_sum, prod_q[31:1]};
    assign prod_fix = neg_q ? -prod_nxt : prod_nxt;
    assign quo_fix  = neg_q ? -div_quo : div_quo;
    assign rem_fix  = rneg_q ? -div_rem : div_rem;

`ifdef MUL_DIV_FAST_MUL_EN
    logic signed [65:0] fast_prod;
    assign fast_prod = $signed({a_sgn & src1[31], src1}) * $signed({b_sgn & src2[31], src2});
`endif

    mul_div_divider u_divider (
        .clk       (clk),
        .rst       (rst),
        .load      (div_load),
        .step      (div_step),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        result_d = result_q;
        div_load = 1'b0;
        div_step = 1'b0;
        case (state_q)
            Idle: begin
                if (start && !flush) begin
                    cmd_d   = command;
                    cnt_d   = '0;
                    mcand_d = a_mag;
                    prod_d  = {32'd0, b_mag};
                    neg_d   = (a_sgn & src1[31]) ^ (b_sgn & src2[31]);
                    rneg_d  = a_sgn & src1[31];
                    if (is_mul(command)) begin
`ifdef MUL_DIV_FAST_MUL_EN
                        result_d = (command == Mul) ? fast_prod[31:0] : fast_prod[63:32];
                        state_d  = Done;
`else
                        state_d  = Compute;
`endif
                    end else if (src2 == 32'd0) begin
                        result_d = (command inside {Div, Divu}) ? 32'hFFFF_FFFF : src1;
                        state_d  = Done;
                    end else if ((command inside {Div, Rem}) &&
                                 src1 == 32'h8000_0000 && src2 == 32'hFFFF_FFFF) begin
                        result_d = (command == Div) ? 32'h8000_0000 : 32'd0;
                        state_d  = Done;
                    end else begin
                        div_load = 1'b1;
                        state_d  = Compute;
                    end
                end
            end
            Compute: begin
                cnt_d = cnt_q + 5'd1;
                if (is_mul(cmd_q)) prod_d = prod_nxt;
                else               div_step = 1'b1;
                if (cnt_q == 5'(MulDivIterations - 1)) begin
                    state_d = Done;
                    if (is_mul(cmd_q))
                        result_d = (cmd_q == Mul) ? prod_fix[31:0] : prod_fix[63:32];
                    else
                        result_d = (cmd_q inside {Div, Divu}) ? quo_fix : rem_fix;
                end
            end
            Done:    state_d = Idle;
            default: state_d = Idle;
        endcase
        // Abort wins over everything, including a completion on this edge.
        if (flush) begin
            state_d  = Idle;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= Idle;
            cmd_q    <= Mul;
            cnt_q    <= '0;
            mcand_q  <= '0;
            prod_q   <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            prod_q   <= prod_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q != Idle);
    assign done   = (state_q == Done);
    assign result = result_q;

endmodule

`default_nettype wire

// File: tb/tb_mul_div_unit.sv
// ============================================================================
// Module   : tb_mul_div_unit
// Purpose  : Directed vector bench for mul_div_unit (honours MUL_DIV_FAST_MUL_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_div_unit;
    import OpTypes::*;

`ifdef MUL_DIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    MulDivCommand command = Mul;
    logic [31:0]  src1 = '0;
    logic [31:0]  src2 = '0;
    logic         busy, done;
    logic [31:0]  result;

    int total = 0;
    int bad   = 0;

    mul_div_unit dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .flush   (flush),
        .command (command),
        .src1    (src1),
        .src2    (src2),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        MulDivCommand cmd;
        logic [31:0]  a;
        logic [31:0]  b;
        logic [31:0]  exp;
        int           lat;
    } vec_t;

    vec_t vecs[22];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Issues one command in the current cycle and follows it to its done pulse.
    task automatic run_op(input string name, input MulDivCommand c, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        int cyc;
        logic busy_ok;
        command = c; src1 = a; src2 = b; start = 1'b1;
        tick();
        start = 1'b0;
        src1 = 32'hDEAD_BEEF; src2 = 32'h0BAD_F00D;
        cyc = 1;
        busy_ok = 1'b1;
        while (!done && cyc < 40) begin
            if (!busy) busy_ok = 1'b0;
            tick();
            cyc++;
        end
        check({name, " timeout"}, 32'(done), 32'd1);
        check({name, " latency"}, 32'(cyc), 32'(lat));
        check({name, " result"}, result, exp);
        check({name, " busy"}, 32'(busy_ok & busy), 32'd1);
        tick();
        check({name, " pulse"}, 32'(done), 32'd0);
        check({name, " hold"}, result, exp);
    endtask

    initial begin
        int  seen;
        vecs[0]  = '{Mul,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT};
        vecs[1]  = '{Mulhu,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT};
        vecs[2]  = '{Mulh,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT};
        vecs[3]  = '{Mulhsu, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, MUL_LAT};
        vecs[4]  = '{Mul,    32'h1234_5678, 32'h0000_0010, 32'h2345_6780, MUL_LAT};
        vecs[5]  = '{Mulhu,  32'h1234_5678, 32'h0000_0010, 32'h0000_0001, MUL_LAT};
        vecs[6]  = '{Mulh,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT};
        vecs[7]  = '{Div,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, DIV_LAT};
        vecs[8]  = '{Rem,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, DIV_LAT};
        vecs[9]  = '{Divu,   32'd100,       32'd7,         32'd14,        DIV_LAT};
        vecs[10] = '{Remu,   32'd100,       32'd7,         32'd2,         DIV_LAT};
        vecs[11] = '{Div,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, DIV_LAT};
        vecs[12] = '{Rem,    32'd7,         32'hFFFF_FFFE, 32'd1,         DIV_LAT};
        vecs[13] = '{Divu,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         DIV_LAT};
        vecs[14] = '{Remu,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, DIV_LAT};
        vecs[15] = '{Div,    32'h8000_0000, 32'd1,         32'h8000_0000, DIV_LAT};
        vecs[16] = '{Divu,   32'd9,         32'd0,         32'hFFFF_FFFF, 1};
        vecs[17] = '{Remu,   32'd5,         32'd0,         32'd5,         1};
        vecs[18] = '{Div,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[19] = '{Rem,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1};
        vecs[20] = '{Div,    32'd0,         32'd0,         32'hFFFF_FFFF, 1};
        vecs[21] = '{Rem,    32'h8000_0000, 32'd0,         32'h8000_0000, 1};

        tick();
        tick();
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", result, 32'd0);
        rst = 1'b0;
        tick();

        foreach (vecs[i])
            run_op($sformatf("vec%0d %s", i, vecs[i].cmd.name()),
                   vecs[i].cmd, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

        // A start while busy must not disturb the running divide.
        command = Divu; src1 = 32'd100; src2 = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        seen = 1;
        while (!done && seen < 40) begin
            if (seen == 5) begin
                command = Mul; src1 = 32'd3; src2 = 32'd5; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            seen++;
        end
        start = 1'b0;
        check("busy start latency", 32'(seen), 32'd33);
        check("busy start result", result, 32'd14);
        tick();

        // Flush at T+10: idle at T+11 with no pulse, then a clean restart.
        command = Divu; src1 = 32'd100; src2 = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        seen = 0;
        for (int k = 1; k <= 10; k++) begin
            if (done) seen++;
            flush = (k == 10);
            tick();
        end
        flush = 1'b0;
        check("flush busy", 32'(busy), 32'd0);
        check("flush pulses", 32'(seen + int'(done)), 32'd0);
        check("flush result kept", result, 32'd14);
        run_op("after flush", Div, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, DIV_LAT);

        // Start and flush together in Idle: start is dropped.
        command = Div; src1 = 32'd50; src2 = 32'd5; start = 1'b1; flush = 1'b1;
        tick();
        start = 1'b0; flush = 1'b0;
        check("flush+start busy", 32'(busy), 32'd0);
        tick();
        check("flush+start done", 32'(done), 32'd0);

        // Reset at T+20 of a divide.
        command = Divu; src1 = 32'd100; src2 = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k < 20; k++) tick();
        check("mid-op busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst result", result, 32'd0);
        tick();
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (done || busy) seen++;
            tick();
        end
        check("post-rst quiet", 32'(seen), 32'd0);
        run_op("post-rst op", Mul, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
